// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and defaults for the UART transmit arbiter: FSM encoding,
// default gap/timeout lengths and a constant helper for counter sizing.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_GAP    = 3'd5
  } state_t;

  localparam int DEF_GAP_CYCLES = 16;
  localparam int DEF_TIMEOUT    = 50000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_cycle_timer.sv
// Clear/enable up-counter that saturates at all-ones; tc is high once the
// count has reached the supplied terminal value.
module cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count >= term);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between two byte-stream requesters, granting
// whole frames round-robin with a starvation timeout and an inter-frame gap.
//
//   state  | meaning
//   IDLE   | no frame in flight; grant the next requester when uart is free
//   SEND   | tx_stb high with the captured byte
//   SETTLE | one cycle for the uart to raise tx_busy
//   WAIT   | byte on the wire, hold until tx_busy drops
//   NEXT   | owner may present its next byte; timeout counter runs
//   GAP    | enforced idle time before the next frame may start
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_stb,
  input  logic       tx_busy,
  output logic       owner,
  output logic       frame_active,
  output logic       abort
);

  localparam int CNT_W = $clog2(max_int(GAP_CYCLES, TIMEOUT) + 1);
  localparam logic [CNT_W-1:0] GAP_TERM = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(TIMEOUT - 1);

  state_t state;
  logic   last_owner;
  logic   cap_last;
  logic   pick;
  logic   own_valid;
  logic   accept;
  logic   sel_last;
  logic [7:0] sel_data;
  logic   gap_done;
  logic   to_done;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    if (req0_valid && req1_valid) begin
      pick = ~last_owner;
    end else if (req1_valid) begin
      pick = 1'b1;
    end
  end

  assign own_valid = owner ? req1_valid : req0_valid;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (!tx_busy) begin
            req0_ready = req0_valid && !pick;
            req1_ready = req1_valid && pick;
          end
        end
        ST_NEXT: begin
          req0_ready = !owner && req0_valid;
          req1_ready = owner && req1_valid;
        end
        default: begin
          req0_ready = 1'b0;
          req1_ready = 1'b0;
        end
      endcase
    end
  end

  assign accept   = req0_ready || req1_ready;
  assign sel_data = req1_ready ? req1_data : req0_data;
  assign sel_last = req1_ready ? req1_last : req0_last;

  cycle_timer #(.WIDTH(CNT_W)) u_gap_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (state != ST_GAP),
    .en   (state == ST_GAP),
    .term (GAP_TERM),
    .tc   (gap_done)
  );

  // Counts only idle NEXT cycles; an accept restarts it via the state change.
  cycle_timer #(.WIDTH(CNT_W)) u_to_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state != ST_NEXT) || accept),
    .en   ((state == ST_NEXT) && !own_valid),
    .term (TO_TERM),
    .tc   (to_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tx_stb       <= 1'b0;
      tx_data      <= 8'h00;
      owner        <= 1'b0;
      frame_active <= 1'b0;
      abort        <= 1'b0;
      last_owner   <= 1'b1;
      cap_last     <= 1'b0;
    end else begin
      tx_stb <= 1'b0;
      abort  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tx_data      <= sel_data;
            cap_last     <= sel_last;
            owner        <= req1_ready;
            frame_active <= 1'b1;
            tx_stb       <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND:   state <= ST_SETTLE;
        ST_SETTLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!tx_busy) begin
            state <= cap_last ? ST_GAP : ST_NEXT;
          end
        end
        ST_NEXT: begin
          // A byte arriving on the terminal cycle is still taken.
          if (accept) begin
            tx_data  <= sel_data;
            cap_last <= sel_last;
            tx_stb   <= 1'b1;
            state    <= ST_SEND;
          end else if (to_done) begin
            abort <= 1'b1;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            frame_active <= 1'b0;
            last_owner   <= owner;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple uart busy model and two
// queue-driven requesters; expected cycle offsets are derived by hand.
module tb_uart_tx_arbiter;

  localparam int GAP = 16;
  localparam int TO  = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data, req1_data, tx_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       tx_stb, tx_busy, owner, frame_active, abort;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_stb(tx_stb), .tx_busy(tx_busy),
    .owner(owner), .frame_active(frame_active), .abort(abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] stb_data[$];
  logic       stb_own[$];
  int         stb_cyc[$];
  int abort_cnt = 0, dbl = 0, atom_viol = 0, busy_viol = 0;
  logic busy_force = 1'b0;
  logic acc0, acc1;

  // uart: busy rises the cycle after the strobe and stays up for 10 cycles
  initial begin
    int bcnt;
    logic pend;
    bcnt = 0; pend = 1'b0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bcnt > 0) bcnt--;
      if (pend) begin bcnt = 10; pend = 1'b0; end
      if (tx_stb) pend = 1'b1;
      tx_busy = busy_force || (bcnt > 0);
    end
  end

  initial begin
    acc0 = 1'b0; req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    forever begin
      @(negedge clk);
      if (acc0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0) begin
        req0_valid = 1'b1; {req0_last, req0_data} = q0[0];
      end else begin
        req0_valid = 1'b0; req0_last = 1'b0; req0_data = 8'h00;
      end
      #4;
      acc0 = req0_valid && req0_ready;
    end
  end

  initial begin
    acc1 = 1'b0; req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    forever begin
      @(negedge clk);
      if (acc1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1'b1; {req1_last, req1_data} = q1[0];
      end else begin
        req1_valid = 1'b0; req1_last = 1'b0; req1_data = 8'h00;
      end
      #4;
      acc1 = req1_valid && req1_ready;
    end
  end

  initial begin
    logic prev_stb;
    prev_stb = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (tx_stb) begin
        stb_data.push_back(tx_data);
        stb_own.push_back(owner);
        stb_cyc.push_back(cyc);
      end
      if (tx_stb && prev_stb) dbl++;
      prev_stb = tx_stb;
      if (abort) abort_cnt++;
      if ((req0_ready || req1_ready) && tx_busy) busy_viol++;
      if (frame_active && ((!owner && req1_ready) || (owner && req0_ready))) atom_viol++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #3;
  endtask

  task automatic goto(input int t);
    if (t > cyc) step(t - cyc);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stb(input int n_before, output int c);
    int k;
    k = 0;
    while (stb_cyc.size() <= n_before && k < 200) begin
      step(1);
      k++;
    end
    check("stb_arrived", stb_cyc.size() > n_before, 1);
    c = (stb_cyc.size() > n_before) ? stb_cyc[n_before] : 0;
  endtask

  initial begin
    int c0, s0, s1, s3, s, g, h, h2, c, j, k1, l;

    // reset values while both requesters already present a byte
    step(3);
    q0 = '{9'h1C0, 9'h0A1, 9'h0A2, 9'h1A3};
    q1 = '{9'h1B1};
    step(1);
    check("rst_tx_stb", tx_stb, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_owner", owner, 0);
    check("rst_frame_active", frame_active, 0);
    check("rst_abort", abort, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    c0 = cyc;
    rst = 1'b0;

    // tie after reset goes to req0, then the next tie goes to req1
    wait_stb(0, s0);
    check("first_stb_latency", s0 - c0, 1);
    check("tie0_data", stb_data[0], 8'hC0);
    check("tie0_owner", stb_own[0], 0);
    goto(s0 + 28);
    check("gap_end_fa_low", frame_active, 0);
    check("tie1_req1_ready", req1_ready, 1);
    check("tie1_req0_ready", req0_ready, 0);
    wait_stb(1, s1);
    check("tie1_spacing", s1 - s0, 29);
    check("tie1_data", stb_data[1], 8'hB1);
    check("tie1_owner", stb_own[1], 1);

    // three-byte frame from req0
    wait_stb(4, s3);
    check("frm_b0", stb_data[2], 8'hA1);
    check("frm_b1", stb_data[3], 8'hA2);
    check("frm_b2", stb_data[4], 8'hA3);
    check("frm_b0_cyc", stb_cyc[2] - s1, 29);
    check("frm_b1_cyc", stb_cyc[3] - s1, 42);
    check("frm_b2_cyc", stb_cyc[4] - s1, 55);
    goto(s3 + 27);
    check("gap_last_fa_high", frame_active, 1);
    step(1);
    check("gap_done_fa_low", frame_active, 0);

    // req1 shows up mid-frame and must wait for the whole frame plus gap
    q0 = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h1D3};
    wait_stb(6, s);
    q1 = '{9'h1E0};
    step(2);
    check("atom_req1_valid", req1_valid, 1);
    check("atom_req1_ready", req1_ready, 0);
    wait_stb(9, s);
    check("atom_d2", stb_data[7], 8'hD2);
    check("atom_d3", stb_data[8], 8'hD3);
    check("atom_e0", stb_data[9], 8'hE0);
    check("atom_e0_owner", stb_own[9], 1);
    check("atom_e0_cyc", stb_cyc[9] - stb_cyc[8], 29);

    // timeout: one non-last byte then silence
    goto(s + 28);
    q0 = '{9'h0F0};
    wait_stb(10, s);
    check("to_owner", stb_own[10], 0);
    goto(s + 31);
    check("to_abort_early", abort, 0);
    step(1);
    check("to_abort_pulse", abort, 1);
    check("to_fa_in_gap", frame_active, 1);
    step(1);
    check("to_abort_one_cycle", abort, 0);
    check("to_abort_count", abort_cnt, 1);
    goto(s + 35);
    q1 = '{9'h1C1};
    goto(s + 48);
    check("to_gap_end_fa", frame_active, 0);
    wait_stb(11, g);
    check("to_next_grant_cyc", g - s, 49);
    check("to_next_grant_owner", stb_own[11], 1);

    // owner returns exactly on the terminal cycle: accept, no abort
    q0 = '{9'h0E1};
    wait_stb(12, h);
    goto(h + 30);
    q0.push_back(9'h1E2);
    wait_stb(13, h2);
    check("to_race_cyc", h2 - h, 32);
    check("to_race_data", stb_data[13], 8'hE2);
    check("to_race_no_abort", abort_cnt, 1);

    // busy held in IDLE blocks the grant
    goto(h2 + 28);
    busy_force = 1'b1;
    q0 = '{9'h1F7};
    step(5);
    check("busy_req0_ready", req0_ready, 0);
    check("busy_no_stb", stb_cyc.size(), 14);
    busy_force = 1'b0;
    c = cyc;
    wait_stb(14, j);
    check("busy_release_cyc", j - c, 2);

    // reset during WAIT of byte 2 of 4 from req1
    goto(j + 28);
    q1 = '{9'h030, 9'h031, 9'h032, 9'h133};
    wait_stb(16, k1);
    goto(k1 + 5);
    check("mid_owner_before", owner, 1);
    rst = 1'b1;
    q1.delete();
    #1;
    check("mid_rst_tx_stb", tx_stb, 0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_owner", owner, 0);
    check("mid_rst_fa", frame_active, 0);
    check("mid_rst_abort", abort, 0);
    check("mid_rst_req1_ready", req1_ready, 0);
    step(3);
    rst = 1'b0;
    step(30);
    check("mid_no_more_stb", stb_cyc.size(), 17);
    q0 = '{9'h155};
    q1 = '{9'h166};
    wait_stb(17, l);
    check("post_rst_data", stb_data[17], 8'h55);
    check("post_rst_owner", stb_own[17], 0);

    check("stb_single_cycle", dbl, 0);
    check("no_interleave", atom_viol, 0);
    check("no_ready_when_busy", busy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
